// File: rtl/fluorescence_acq_sequencer.sv
// fluorescence_acq_sequencer
// Lock-in acquisition controller for the PMT photon-counting path. It toggles
// the light source every half-period, blanks the first cycles of each
// half-period and counts pulse events into add (light on) or sub (light off).
// At each frame end the signed difference is handed out over valid/ready.
// Optional macro: FLUOR_SEQ_SATURATE_EN makes the counters saturate instead of
// wrapping, and an event at saturation sets overrun.
module fluorescence_acq_sequencer #(
  parameter int CNT_W    = 32,
  parameter int PERIOD_W = 32,
  parameter int HP_W     = 16
) (
  input  logic                clock_50_mhz,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] half_period,
  input  logic [PERIOD_W-1:0] blank_cycles,
  input  logic [HP_W-1:0]     half_periods_per_frame,
  input  logic                pulse_event,
  output logic                light_source_pin,
  output logic                counting,
  output logic                busy,
  output logic                cfg_error,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [CNT_W-1:0]    result_value,
  output logic [CNT_W-1:0]    add_total,
  output logic [CNT_W-1:0]    sub_total,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, BLANK, COUNT} state_t;

  state_t                     state, state_next;
  logic [PERIOD_W-1:0]        half_q, blank_q, cyc;
  logic [HP_W-1:0]            hpf_q, hp_idx;
  logic                       stop_pend;
  logic [CNT_W-1:0]           add_cnt, sub_cnt, add_sum, sub_sum;
  logic signed [CNT_W-1:0]    diff;
  logic                       cfg_ok, hp_end, frame_end, add_inc, sub_inc;
  logic                       sat_hit, load_result, stalled;

  // Counter increment; saturating or wrapping depending on the build.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc);
`ifdef FLUOR_SEQ_SATURATE_EN
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
`else
    return v + CNT_W'(inc);
`endif
  endfunction

  assign cfg_ok = (half_period >= PERIOD_W'(2)) && (blank_cycles < half_period) &&
                  !half_periods_per_frame[0] && (half_periods_per_frame >= HP_W'(2));

  assign counting  = (state == COUNT);
  assign busy      = (state != IDLE);
  assign hp_end    = busy && (cyc == half_q - PERIOD_W'(1));
  assign frame_end = hp_end && (hp_idx == hpf_q - HP_W'(1));
  assign add_inc   = counting && pulse_event && light_source_pin;
  assign sub_inc   = counting && pulse_event && !light_source_pin;
  assign add_sum   = bump(add_cnt, add_inc);
  assign sub_sum   = bump(sub_cnt, sub_inc);
  assign diff      = $signed(add_sum) - $signed(sub_sum);
  assign stalled   = result_valid && !result_ready;
  assign load_result = frame_end && !stalled;

`ifdef FLUOR_SEQ_SATURATE_EN
  assign sat_hit = (add_inc && (add_cnt == {CNT_W{1'b1}})) ||
                   (sub_inc && (sub_cnt == {CNT_W{1'b1}}));
`else
  assign sat_hit = 1'b0;
`endif

  // Next-state logic: blanking window, counting window, frame/stop handling.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start && cfg_ok) state_next = (blank_cycles == '0) ? COUNT : BLANK;
      BLANK: if (cyc == blank_q - PERIOD_W'(1)) state_next = COUNT;
      COUNT: if (hp_end) begin
               if (frame_end && (stop_pend || stop)) state_next = IDLE;
               else state_next = (blank_q == '0) ? COUNT : BLANK;
             end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_50_mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Timing counters, light phase, config latch and photon counters.
  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      half_q <= '0; blank_q <= '0; hpf_q <= '0;
      cyc <= '0; hp_idx <= '0; light_source_pin <= 1'b0; stop_pend <= 1'b0;
      add_cnt <= '0; sub_cnt <= '0; cfg_error <= 1'b0;
    end else begin
      cfg_error <= (state == IDLE) && start && !cfg_ok;
      if (state == IDLE) begin
        cyc <= '0; hp_idx <= '0; stop_pend <= 1'b0;
        add_cnt <= '0; sub_cnt <= '0;
        if (start && cfg_ok) begin
          half_q <= half_period; blank_q <= blank_cycles; hpf_q <= half_periods_per_frame;
          light_source_pin <= 1'b1;
        end else begin
          light_source_pin <= 1'b0;
        end
      end else begin
        if (hp_end) begin
          cyc <= '0;
          if (frame_end) begin
            hp_idx <= '0;
            light_source_pin <= !(stop_pend || stop);
          end else begin
            hp_idx <= hp_idx + HP_W'(1);
            light_source_pin <= !light_source_pin;
          end
        end else begin
          cyc <= cyc + PERIOD_W'(1);
        end
        if (frame_end) begin
          stop_pend <= 1'b0;
          add_cnt <= '0; sub_cnt <= '0;
        end else begin
          if (stop) stop_pend <= 1'b1;
          add_cnt <= add_sum; sub_cnt <= sub_sum;
        end
      end
    end
  end

  // Result handshake; a frame ending against a stalled result is dropped.
  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      result_valid <= 1'b0; result_value <= '0;
      add_total <= '0; sub_total <= '0; overrun <= 1'b0;
    end else begin
      if (load_result) begin
        result_valid <= 1'b1;
        add_total    <= add_sum;
        sub_total    <= sub_sum;
        result_value <= diff;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
      if ((frame_end && stalled) || sat_hit) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fluorescence_acq_sequencer.sv
// Directed bench for fluorescence_acq_sequencer (default build, wrapping counters).
module tb_fluorescence_acq_sequencer;

  logic        clock_50_mhz = 1'b0;
  logic        reset, start, stop, pulse_event, result_ready;
  logic [31:0] half_period, blank_cycles;
  logic [15:0] half_periods_per_frame;
  logic        light_source_pin, counting, busy, cfg_error, result_valid, overrun;
  logic [31:0] result_value, add_total, sub_total;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0; // 0 none, 1 held high, 2 light-on only, 3 blanking only

  fluorescence_acq_sequencer dut (
    .clock_50_mhz(clock_50_mhz), .reset(reset), .start(start), .stop(stop),
    .half_period(half_period), .blank_cycles(blank_cycles),
    .half_periods_per_frame(half_periods_per_frame), .pulse_event(pulse_event),
    .light_source_pin(light_source_pin), .counting(counting), .busy(busy),
    .cfg_error(cfg_error), .result_valid(result_valid), .result_ready(result_ready),
    .result_value(result_value), .add_total(add_total), .sub_total(sub_total),
    .overrun(overrun)
  );

  always #10 clock_50_mhz = ~clock_50_mhz;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles; each step lands mid-cycle and sets pulse_event per mode.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clock_50_mhz);
      pulse_event = (mode == 1) || (mode == 2 && light_source_pin) ||
                    (mode == 3 && busy && !counting);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pulse_event = 1'b0; result_ready = 1'b0;
    half_period = 32'd10; blank_cycles = 32'd2; half_periods_per_frame = 16'd2;
    run(3);
    chk("rst_light", light_source_pin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_counting", counting, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", result_value, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    run(1);

    // Frame 1: events held high, readout stalled; start edge is t.
    mode = 1; start = 1'b1;
    run(1);                              // cycle t+1
    start = 1'b0;
    chk("f1_busy", busy, 1);
    chk("f1_light", light_source_pin, 1);
    chk("f1_blank", counting, 0);
    run(2);                              // t+3
    chk("f1_count", counting, 1);
    run(17);                             // t+20
    chk("f1_valid_early", result_valid, 0);
    chk("f1_light_off", light_source_pin, 0);
    run(1);                              // t+21
    chk("f1_valid", result_valid, 1);
    chk("f1_add", add_total, 8);
    chk("f1_sub", sub_total, 8);
    chk("f1_result", result_value, 0);
    chk("f1_next_light", light_source_pin, 1);
    chk("f1_overrun", overrun, 0);

    // Frame 2: light-on events only; dropped because result still held.
    mode = 2;
    run(20);                             // t+41
    chk("f2_overrun", overrun, 1);
    chk("f2_valid", result_valid, 1);
    chk("f2_add_held", add_total, 8);
    chk("f2_sub_held", sub_total, 8);

    // Frame 3: stop mid-frame, ready rises on the frame's last cycle.
    run(4);                              // t+45
    stop = 1'b1;
    run(1);
    stop = 1'b0;
    run(14);                             // t+60
    chk("f3_busy_last", busy, 1);
    result_ready = 1'b1;
    run(1);                              // t+61
    chk("f3_valid", result_valid, 1);
    chk("f3_add", add_total, 8);
    chk("f3_sub", sub_total, 0);
    chk("f3_result", result_value, 8);
    chk("f3_busy", busy, 0);
    chk("f3_light", light_source_pin, 0);
    run(1);                              // t+62
    chk("f3_valid_drop", result_valid, 0);

    // Reset in mid-frame discards everything.
    mode = 1; start = 1'b1;
    run(1);
    start = 1'b0;
    run(4);                              // fifth cycle of the frame
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_light", light_source_pin, 0);
    chk("mr_add", add_total, 0);
    chk("mr_result", result_value, 0);
    chk("mr_overrun", overrun, 0);

    // Rejected configurations.
    mode = 0; blank_cycles = 32'd10; start = 1'b1;
    run(1);
    start = 1'b0;
    chk("ce1_pulse", cfg_error, 1);
    chk("ce1_busy", busy, 0);
    run(1);
    chk("ce1_clear", cfg_error, 0);
    blank_cycles = 32'd2; half_periods_per_frame = 16'd3; start = 1'b1;
    run(1);
    start = 1'b0;
    chk("ce2_pulse", cfg_error, 1);
    chk("ce2_busy", busy, 0);
    run(1);
    chk("ce2_clear", cfg_error, 0);
    half_periods_per_frame = 16'd2;

    // Frame 4: events only during blanking, stop requested.
    mode = 3; start = 1'b1;
    run(1);                              // s+1
    start = 1'b0;
    chk("f4_busy", busy, 1);
    run(2);                              // s+3
    stop = 1'b1;
    run(1);
    stop = 1'b0;
    run(17);                             // s+21
    chk("f4_valid", result_valid, 1);
    chk("f4_add", add_total, 0);
    chk("f4_sub", sub_total, 0);
    chk("f4_result", result_value, 0);
    chk("f4_busy", busy, 0);
    run(1);
    chk("f4_valid_drop", result_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fluorescence_acq_sequencer.md
# fluorescence_acq_sequencer

Acquisition controller for the PMT photon-counting lock-in path. It drives the modulated light source and gates PMT pulse events into the add and subtract counters. Each light half-period opens with a blanking window so LED turn-on/turn-off transients are not counted. At the end of every frame it hands a signed result to the readout over a valid/ready handshake. It sits between the PMT pulse synchronizer (single-cycle `pulse_event` strobes) and the probe/readout logic.

## Interface
Parameters:
- `CNT_W`, 32: width of the add/subtract counters and result.
- `PERIOD_W`, 32: width of the timing configuration inputs.
- `HP_W`, 16: width of the half-periods-per-frame count.

Ports:
- `clock_50_mhz` in 1: the single clock; every register is clocked on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level, sampled in IDLE only.
- `stop` in 1: single-cycle request to finish the current frame, then go idle.
- `half_period` in PERIOD_W: cycles per light half-period; minimum 2.
- `blank_cycles` in PERIOD_W: ignored cycles at the start of each half-period; must be < `half_period`.
- `half_periods_per_frame` in HP_W: frame length in half-periods; must be even and ≥ 2.
- `pulse_event` in 1: synchronized one-cycle photon strobe.
- `light_source_pin` out 1: 1 = light on.
- `counting` out 1: high on cycles where `pulse_event` is accepted.
- `busy` out 1: high whenever the state is not IDLE.
- `cfg_error` out 1: one-cycle pulse when a start is rejected.
- `result_valid` out 1, `result_ready` in 1: output handshake.
- `result_value` out CNT_W: signed `add - sub`.
- `add_total`, `sub_total` out CNT_W: the raw counts behind `result_value`.
- `overrun` out 1: sticky; cleared only by `reset`.

## Operation
- States: IDLE, BLANK, COUNT.
- **IDLE:** light off, counters zero.
  - `start`=1 with valid config: latch all three config inputs, go to BLANK, phase on.
  - `start`=1 with invalid config: pulse `cfg_error`, stay in IDLE.
- **BLANK:** the first `blank_cycles` cycles of a half-period; `counting`=0. With `blank_cycles`=0, go straight to COUNT.
- **COUNT:** the remaining cycles of the half-period; `counting`=1.
  - `pulse_event` increments `add` while the light is on, `sub` while it is off.
- **Half-period end:** toggle `light_source_pin`, increment the half-period index, return to BLANK.
- **Frame end** (last cycle of half-period index N-1):
  - Load `add_total`, `sub_total` and `result_value` = `$signed(add) - $signed(sub)`, including any event in that last cycle.
  - Assert `result_valid` and clear the counters.
  - With no pending stop, the next frame starts immediately with light on; acquisition is gap-free.
- **Stop:** `stop` latches a pending flag. At the next frame end the result is delivered, then the block enters IDLE with the light off. A `stop` received while IDLE has no effect.
- **Handshake:**
  - A transfer occurs on a cycle where `result_valid`=1 and `result_ready`=1.
  - `result_valid` drops on the following cycle unless a new result loads on that same edge, in which case it stays high with the new data.
  - If a frame ends while `result_valid`=1 and `result_ready`=0: keep the held result, drop the new one, set `overrun`.
- **Arithmetic:** the subtraction wraps modulo 2^CNT_W.
- **Reset values:** every output is 0 and the state is IDLE. A `reset` in mid-frame aborts the frame and discards all counts.

## Timing
- `start` sampled in IDLE at edge t: `light_source_pin`=1 and `busy`=1 from cycle t+1.
- Half-period k occupies cycles t+1+kH … t+(k+1)H, where H = `half_period`.
- `counting` is combinational from state. An event is accepted in the same cycle it is present; the counter value updates on the next edge.
- `result_valid` rises the cycle after the frame's last cycle. In that same cycle the light is already on for the next frame.
- Config changes while busy have no effect until the next `start`.

## Configuration
- `FLUOR_SEQ_SATURATE_EN` defined: `add` and `sub` saturate at 2^CNT_W−1. An event arriving at saturation sets `overrun`.
- Not defined: the counters wrap silently, and `overrun` reflects output backpressure only.

## Test plan
- H=10, blank=2, N=2, `pulse_event` held high → `add_total`=8, `sub_total`=8, `result_value`=0; `result_valid` rises 21 cycles after the `start` edge.
- Same config, events only while light is on → 8, 0, `result_value`=8. Events only during blanking → 0, 0, 0.
- `result_ready` held 0 across two frames → first result retained, `overrun`=1. Then `ready`=1 → one transfer and `valid` drops, or the new frame's data loads if a frame ends on that same edge.
- `stop` pulsed mid-frame → frame completes and its result is delivered. Next cycle `busy`=0 and `light_source_pin`=0.
- `start` with `blank_cycles`=10 and H=10, or N=3 → `cfg_error` pulses for one cycle and `busy` stays 0.
- `reset` at cycle 5 of a frame → all outputs 0. With `FLUOR_SEQ_SATURATE_EN` and CNT_W=4: 20 on-phase events → `add_total`=15 and `overrun`=1.
